csa_tree_pipe: RTL
==================

# csa_tree_pipe

Parametrised, pipelined multi-operand modular adder for the SHA-256 datapath. Reduces NUM_OPS operands of WIDTH bits to one sum modulo 2^WIDTH: a carry-save tree produces a sum/carry pair, then a carry-propagate adder resolves it. A valid/ready handshake with per-stage backpressure and an opaque tag travelling alongside each sample let the round logic stall it freely. It generalises the fixed 4/5/7-operand reducers to any operand count from 3 to 8.

## Interface
- WIDTH, 32, operand and result width in bits (>= 2)
- NUM_OPS, 7, operand count, legal range 3..8; other values fail elaboration
- TAG_W, 4, width of the sideband tag (>= 1)

- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_valid  input  1  input sample valid
- o_ready  output  1  block accepts a sample this cycle
- i_ops  input  NUM_OPS*WIDTH  packed operands; operand k at bits [k*WIDTH +: WIDTH]
- i_tag  input  TAG_W  sideband tag, returned unchanged with the result
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts the result this cycle
- o_sum  output  WIDTH  (sum of all operands) mod 2^WIDTH
- o_tag  output  TAG_W  tag of the sample in o_sum
- o_busy  output  1  at least one stage holds a valid sample

## Operation
- Transfer in: i_valid && o_ready. Transfer out: o_valid && i_ready.
- Stage CS (registered): 3:2 full-adder layers reduce NUM_OPS operands to a sum vector S and a carry vector C. C is shifted left by one; the carry out of bit WIDTH-1 is discarded at every layer.
- Stage CP (registered): o_sum = S + C, truncated to WIDTH bits. The final carry is discarded.
- Each stage has one valid bit plus its data/tag register. A stage loads when it is empty or its contents advance in the same cycle:
  - advance_CP = !cp_valid || i_ready
  - advance_CS = !cs_valid || advance_CP
  - o_ready = advance_CS (combinational from i_ready)
- Bubbles collapse. An empty stage never blocks upstream.
- Data and tag registers load only when their stage loads. Held data stays stable while o_valid && !i_ready.
- o_valid = cp_valid; o_busy = OR of all stage valid bits.
- Ordering: results leave strictly in acceptance order. No sample is dropped or duplicated except at reset.
- Arithmetic is unsigned modulo 2^WIDTH. Overflow is silent and there is no carry-out port.

## Timing
- Reset: all valid bits 0, o_sum = 0, o_tag = 0, o_busy = 0. o_ready = 1 in the first cycle after reset.
- Reset asserted mid-operation discards every in-flight sample on the next edge. i_rst has priority over all loads.
- Latency, macro absent: a sample accepted at edge n appears on o_sum with o_valid=1 after edge n+2.
- Throughput: one sample per cycle while i_ready=1.
- Full condition: all stages valid and i_ready=0 gives o_ready=0 in that same cycle. When i_ready rises, o_ready rises in the same cycle.
- Simultaneous accept and release in a full pipe is allowed and sustains full rate.

## Configuration
- CSA_TREE_PIPE_IN_REG_EN defined:
  - Adds an input register stage IN ahead of CS, holding i_ops/i_tag/valid.
  - advance_IN = !in_valid || advance_CS, and o_ready = advance_IN.
  - Latency 3 cycles; capacity 3 samples.
  - The CS tree reads registered operands.
- Undefined: the CS tree reads i_ops directly; latency 2, capacity 2.
- Handshake semantics, ordering and reset values are identical in both builds.

## Test plan
- Single sample, NUM_OPS=7, WIDTH=32, operands 1,2,3,4,5,6,7, tag 5, i_ready held 1 -> o_sum=28, o_tag=5, o_valid for exactly one cycle, 2 cycles after accept (3 with macro).
- Overflow: seven operands of 0xFFFF_FFFF -> o_sum=0xFFFF_FFF9; NUM_OPS=3 with 0x8000_0000 ×3 -> 0x8000_0000.
- Streaming: 100 random back-to-back samples, i_ready=1 -> 100 results in order matching a reference model, one per cycle after the latency.
- Backpressure: i_ready=0 for 10 cycles while i_valid=1 -> o_ready drops once the pipe is full (after 2 accepts, 3 with macro), o_sum/o_tag are stable and no sample is lost. On release, remaining results appear in order.
- Random i_valid/i_ready toggling (50% each), NUM_OPS in {3,4,5,8}, WIDTH in {8,32} -> scoreboard match, no duplicates.
- i_rst asserted for one cycle with the pipe full -> o_valid=0, o_busy=0, o_sum=0 next cycle, o_ready=1. Pre-reset samples never appear.

Source files
------------

// File: rtl/csa_tree_pipe_if.sv
// Handshake/data bundle for csa_tree_pipe: operand/tag input channel and result channel.
// slave is the adder's view, master the producer/consumer view.
interface csa_tree_pipe_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_OPS = 7,
  parameter int unsigned TAG_W   = 4
);
  logic                     i_valid;
  logic                     o_ready;
  logic [NUM_OPS*WIDTH-1:0] i_ops;
  logic [TAG_W-1:0]         i_tag;
  logic                     o_valid;
  logic                     i_ready;
  logic [WIDTH-1:0]         o_sum;
  logic [TAG_W-1:0]         o_tag;
  logic                     o_busy;

  modport slave (
    input  i_valid, i_ops, i_tag, i_ready,
    output o_ready, o_valid, o_sum, o_tag, o_busy
  );

  modport master (
    output i_valid, i_ops, i_tag, i_ready,
    input  o_ready, o_valid, o_sum, o_tag, o_busy
  );
endinterface

// File: rtl/csa_tree_pipe.sv
// Pipelined NUM_OPS-operand modular adder: 3:2 carry-save tree stage then carry-propagate stage,
// valid/ready with per-stage backpressure. CSA_TREE_PIPE_IN_REG_EN adds an input register stage.
module csa_tree_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_OPS = 7,
  parameter int unsigned TAG_W   = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  csa_tree_pipe_if.slave bus
);

  localparam int unsigned NUM_CSA   = NUM_OPS - 2;
  localparam int unsigned NUM_NODES = NUM_OPS + 2 * NUM_CSA;
  localparam int unsigned OPS_W     = NUM_OPS * WIDTH;

  if (NUM_OPS < 3 || NUM_OPS > 8) begin : g_bad_num_ops
    $error("csa_tree_pipe: NUM_OPS must be in 3..8");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("csa_tree_pipe: WIDTH must be at least 2");
  end
  if (TAG_W < 1) begin : g_bad_tag_w
    $error("csa_tree_pipe: TAG_W must be at least 1");
  end

  logic               advance_cs;
  logic               advance_cp;

  logic               tree_valid;
  logic [OPS_W-1:0]   tree_ops;
  logic [TAG_W-1:0]   tree_tag;
  logic               in_busy;

  logic [WIDTH-1:0]   node [NUM_NODES];
  logic [WIDTH-1:0]   tree_s;
  logic [WIDTH-1:0]   tree_c;

  logic               cs_valid;
  logic [WIDTH-1:0]   cs_s;
  logic [WIDTH-1:0]   cs_c;
  logic [TAG_W-1:0]   cs_tag;

  logic               cp_valid;
  logic [WIDTH-1:0]   cp_sum;
  logic [TAG_W-1:0]   cp_tag;

  assign advance_cp = !cp_valid || bus.i_ready;
  assign advance_cs = !cs_valid || advance_cp;

`ifdef CSA_TREE_PIPE_IN_REG_EN
  logic               in_valid;
  logic [OPS_W-1:0]   in_ops;
  logic [TAG_W-1:0]   in_tag;
  logic               advance_in;

  assign advance_in = !in_valid || advance_cs;

  // Input register stage; the tree sees registered operands.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      in_valid <= 1'b0;
      in_ops   <= '0;
      in_tag   <= '0;
    end else if (advance_in) begin
      in_valid <= bus.i_valid;
      if (bus.i_valid) begin
        in_ops <= bus.i_ops;
        in_tag <= bus.i_tag;
      end
    end
  end

  assign tree_valid  = in_valid;
  assign tree_ops    = in_ops;
  assign tree_tag    = in_tag;
  assign in_busy     = in_valid;
  assign bus.o_ready = advance_in;
`else
  assign tree_valid  = bus.i_valid;
  assign tree_ops    = bus.i_ops;
  assign tree_tag    = bus.i_tag;
  assign in_busy     = 1'b0;
  assign bus.o_ready = advance_cs;
`endif

  // Carry-save tree: compressor j consumes nodes 3j..3j+2 and appends its sum/carry,
  // so operands are reduced layer by layer; the last two nodes are the final S/C pair.
  always_comb begin
    for (int unsigned k = 0; k < NUM_NODES; k++) begin
      node[k] = '0;
    end
    for (int unsigned k = 0; k < NUM_OPS; k++) begin
      node[k] = tree_ops[k*WIDTH +: WIDTH];
    end
    for (int unsigned j = 0; j < NUM_CSA; j++) begin
      node[NUM_OPS + 2*j]     = node[3*j] ^ node[3*j + 1] ^ node[3*j + 2];
      node[NUM_OPS + 2*j + 1] = ((node[3*j] & node[3*j + 1]) |
                                 (node[3*j] & node[3*j + 2]) |
                                 (node[3*j + 1] & node[3*j + 2])) << 1;
    end
    tree_s = node[NUM_NODES - 2];
    tree_c = node[NUM_NODES - 1];
  end

  // CS stage: holds the sum/carry pair.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cs_valid <= 1'b0;
      cs_s     <= '0;
      cs_c     <= '0;
      cs_tag   <= '0;
    end else if (advance_cs) begin
      cs_valid <= tree_valid;
      if (tree_valid) begin
        cs_s   <= tree_s;
        cs_c   <= tree_c;
        cs_tag <= tree_tag;
      end
    end
  end

  // CP stage: resolves S + C; contents hold while the consumer stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cp_valid <= 1'b0;
      cp_sum   <= '0;
      cp_tag   <= '0;
    end else if (advance_cp) begin
      cp_valid <= cs_valid;
      if (cs_valid) begin
        cp_sum <= cs_s + cs_c;
        cp_tag <= cs_tag;
      end
    end
  end

  assign bus.o_valid = cp_valid;
  assign bus.o_sum   = cp_sum;
  assign bus.o_tag   = cp_tag;
  assign bus.o_busy  = in_busy || cs_valid || cp_valid;

endmodule
